// File: rtl/voice_allocator_if.sv
// Command handshake between a note source and the voice allocator.
interface voice_allocator_if;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_data;

  modport master (
    output i_valid,
    output i_data,
    input  o_ready
  );

  modport slave (
    input  i_valid,
    input  i_data,
    output o_ready
  );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off commands onto phase-bank
// voices with retrigger, oldest-voice stealing and a two-cycle kill gap.
module voice_allocator #(
  parameter int NUM_VOICES = 10,
  parameter int AGE_W      = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  voice_allocator_if.slave                  bus,
  input  logic [NUM_VOICES-1:0]             i_st,
  output logic [NUM_VOICES-1:0]             o_cmd,
  output logic [7*NUM_VOICES-1:0]           o_midi,
  output logic [8*NUM_VOICES-1:0]           o_vel,
  output logic                              o_steal,
  output logic                              o_drop,
  output logic [$clog2(NUM_VOICES+1)-1:0]   o_active_cnt
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CW = $clog2(NUM_VOICES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    KILL
  } state_t;

  state_t state, state_n;

  logic [15:0]      hold;
  logic             kill_cnt;
  logic [IW-1:0]    tgt;
  logic [6:0]       midi_q [NUM_VOICES];
  logic [7:0]       vel_q  [NUM_VOICES];
  logic [AGE_W-1:0] age_q  [NUM_VOICES];

  logic             hold_on;
  logic [6:0]       note;
  logic [7:0]       vel;
  assign hold_on = hold[15];
  assign note    = hold[14:8];
  assign vel     = hold[7:0];

  logic             match_hit, free_hit, old_hit;
  logic [IW-1:0]    match_idx, free_idx, old_idx;
  logic [AGE_W-1:0] old_age;
  logic             go_kill;
  logic [IW-1:0]    kill_idx;

  // Descending scan so the lowest index wins; >= gives age ties to it too.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    old_hit   = 1'b0;
    old_idx   = '0;
    old_age   = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (o_cmd[v] && midi_q[v] == note) begin
        match_hit = 1'b1;
        match_idx = IW'(v);
      end
      if (!o_cmd[v] && !i_st[v]) begin
        free_hit = 1'b1;
        free_idx = IW'(v);
      end
      if (o_cmd[v] && (!old_hit || age_q[v] >= old_age)) begin
        old_hit = 1'b1;
        old_idx = IW'(v);
        old_age = age_q[v];
      end
    end
  end

  assign go_kill  = hold_on && (match_hit || (!free_hit && old_hit));
  assign kill_idx = match_hit ? match_idx : old_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.i_valid) state_n = SEARCH;
      SEARCH:  state_n = go_kill ? KILL : IDLE;
      KILL:    if (kill_cnt) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.o_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold     <= '0;
      kill_cnt <= 1'b0;
      tgt      <= '0;
      o_cmd    <= '0;
      o_steal  <= 1'b0;
      o_drop   <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        midi_q[v] <= 7'h7f;
        vel_q[v]  <= '0;
        age_q[v]  <= '0;
      end
    end else begin
      o_steal <= 1'b0;
      o_drop  <= 1'b0;
      case (state)
        IDLE: begin
          kill_cnt <= 1'b0;
          if (bus.i_valid) hold <= bus.i_data;
        end
        SEARCH: begin
          if (hold_on) begin
            if (go_kill) begin
              tgt             <= kill_idx;
              o_cmd[kill_idx] <= 1'b0;
              o_steal         <= !match_hit;
            end else if (free_hit) begin
              o_cmd[free_idx]  <= 1'b1;
              midi_q[free_idx] <= note;
              vel_q[free_idx]  <= vel;
              age_q[free_idx]  <= '0;
            end else begin
              o_drop <= 1'b1;
            end
            // An applied note-on ages every other playing voice.
            if (match_hit || free_hit || old_hit) begin
              for (int v = 0; v < NUM_VOICES; v++) begin
                if (o_cmd[v] && !(go_kill && IW'(v) == kill_idx)
                    && age_q[v] != '1)
                  age_q[v] <= age_q[v] + AGE_W'(1);
              end
            end
          end else if (note == 7'd0) begin
            o_cmd <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
              midi_q[v] <= 7'h7f;
              vel_q[v]  <= '0;
              age_q[v]  <= '0;
            end
          end else if (match_hit) begin
            o_cmd[match_idx]  <= 1'b0;
            midi_q[match_idx] <= 7'h7f;
          end else begin
            o_drop <= 1'b1;
          end
        end
        KILL: begin
          kill_cnt <= 1'b1;
          if (kill_cnt) begin
            o_cmd[tgt]  <= 1'b1;
            midi_q[tgt] <= note;
            vel_q[tgt]  <= vel;
            age_q[tgt]  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_midi       = '0;
    o_vel        = '0;
    o_active_cnt = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      o_midi[7*v +: 7] = midi_q[v];
      o_vel[8*v +: 8]  = vel_q[v];
      o_active_cnt     = o_active_cnt + CW'(o_cmd[v]);
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed scoreboard bench for voice_allocator with a behavioural
// voice model producing the expected state after every command.
module tb_voice_allocator;
  localparam int N = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  voice_allocator_if bus();

  logic [N-1:0]   st;
  logic [N-1:0]   cmd;
  logic [7*N-1:0] midi;
  logic [8*N-1:0] vel;
  logic           steal, drop;
  logic [3:0]     act;

  voice_allocator #(.NUM_VOICES(N), .AGE_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .i_st(st),
    .o_cmd(cmd),
    .o_midi(midi),
    .o_vel(vel),
    .o_steal(steal),
    .o_drop(drop),
    .o_active_cnt(act)
  );

  int vecs = 0;
  int errs = 0;

  bit         mc [N];
  logic [6:0] mm [N];
  logic [7:0] mv [N];
  int         ma [N];

  typedef struct {
    string          tag;
    logic [N-1:0]   cmd;
    logic [7*N-1:0] midi;
    logic [8*N-1:0] vel;
    logic           steal;
    logic           drop;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [79:0] obs,
                     input logic [79:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t snap(input string tag, input logic s,
                                input logic d);
    exp_t r;
    r.tag   = tag;
    r.steal = s;
    r.drop  = d;
    for (int v = 0; v < N; v++) begin
      r.cmd[v]        = mc[v];
      r.midi[7*v +: 7] = mm[v];
      r.vel[8*v +: 8]  = mv[v];
    end
    return r;
  endfunction

  function automatic logic [N-1:0] mcmd();
    logic [N-1:0] r;
    for (int v = 0; v < N; v++) r[v] = mc[v];
    return r;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < N; v++) begin
      mc[v] = 1'b0;
      mm[v] = 7'h7f;
      mv[v] = 8'h00;
      ma[v] = 0;
    end
  endtask

  task automatic age_others(input int skip);
    for (int v = 0; v < N; v++)
      if (mc[v] && v != skip && ma[v] < 255) ma[v]++;
  endtask

  task automatic set_voice(input int v, input logic [6:0] n,
                           input logic [7:0] ve);
    mc[v] = 1'b1;
    mm[v] = n;
    mv[v] = ve;
    ma[v] = 0;
  endtask

  task automatic model(input logic [15:0] d, input string tag,
                       output bit kill);
    logic [6:0] n;
    logic [7:0] ve;
    int m, f, o, best;
    n = d[14:8];
    ve = d[7:0];
    kill = 1'b0;
    m = -1;
    f = -1;
    o = -1;
    best = -1;
    for (int v = 0; v < N; v++) begin
      if (m < 0 && mc[v] && mm[v] == n) m = v;
      if (f < 0 && !mc[v] && !st[v]) f = v;
      if (mc[v] && ma[v] > best) begin
        o = v;
        best = ma[v];
      end
    end
    if (d[15]) begin
      if (m >= 0) begin
        age_others(m);
        mc[m] = 1'b0;
        sb.push_back(snap({tag, "/kill"}, 1'b0, 1'b0));
        set_voice(m, n, ve);
        sb.push_back(snap(tag, 1'b0, 1'b0));
        kill = 1'b1;
      end else if (f >= 0) begin
        age_others(-1);
        set_voice(f, n, ve);
        sb.push_back(snap(tag, 1'b0, 1'b0));
      end else if (o >= 0) begin
        age_others(o);
        mc[o] = 1'b0;
        sb.push_back(snap({tag, "/kill"}, 1'b1, 1'b0));
        set_voice(o, n, ve);
        sb.push_back(snap(tag, 1'b0, 1'b0));
        kill = 1'b1;
      end else begin
        sb.push_back(snap(tag, 1'b0, 1'b1));
      end
    end else if (n == 7'd0) begin
      model_reset();
      sb.push_back(snap(tag, 1'b0, 1'b0));
    end else if (m >= 0) begin
      mc[m] = 1'b0;
      mm[m] = 7'h7f;
      sb.push_back(snap(tag, 1'b0, 1'b0));
    end else begin
      sb.push_back(snap(tag, 1'b0, 1'b1));
    end
  endtask

  task automatic check_out(input exp_t e);
    chk({e.tag, " cmd"},   80'(cmd),   80'(e.cmd));
    chk({e.tag, " midi"},  80'(midi),  80'(e.midi));
    chk({e.tag, " vel"},   80'(vel),   80'(e.vel));
    chk({e.tag, " steal"}, 80'(steal), 80'(e.steal));
    chk({e.tag, " drop"},  80'(drop),  80'(e.drop));
    chk({e.tag, " cnt"},   80'(act),   80'($countones(e.cmd)));
  endtask

  task automatic send(input logic [15:0] d, input string tag);
    bit   kill;
    exp_t e;
    int   n;
    model(d, tag, kill);
    @(negedge clk);
    n = 0;
    while (!bus.o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready"}, 80'(bus.o_ready), 80'(1));
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_data  = 16'h0000;
    chk({tag, " busy"}, 80'(bus.o_ready), 80'(0));
    @(negedge clk);
    e = sb.pop_front();
    check_out(e);
    if (kill) begin
      @(negedge clk);
      chk({tag, " kill2 cmd"},   80'(cmd),   80'(e.cmd));
      chk({tag, " kill2 steal"}, 80'(steal), 80'(0));
      @(negedge clk);
      e = sb.pop_front();
      check_out(e);
    end
    st = mcmd();
  endtask

  initial begin
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data  = 16'h0000;
    st          = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_out(snap("reset", 1'b0, 1'b0));
    chk("reset ready", 80'(bus.o_ready), 80'(1));
    rst = 1'b0;

    send(16'hBC40, "on3c");
    send(16'hBC50, "retrig3c");
    send(16'h4500, "off45_drop");
    send(16'hA011, "on20");
    send(16'hA122, "on21");
    send(16'h0000, "stopall");

    send(16'hA540, "on25");
    send(16'h2500, "off25");
    st[0] = 1'b1;
    send(16'hA640, "on26_skip_rel");
    send(16'hA740, "on27");
    send(16'h0000, "stopall2");

    for (int i = 0; i < 11; i++)
      send({1'b1, 7'(8'h30 + i), 8'(8'h10 + i)}, $sformatf("fill%0d", i));
    send(16'h3500, "off35");
    send(16'hE077, "on60_reuse");
    send(16'hB1AA, "on31_retrig");
    send(16'hF001, "on70_steal");

    send(16'h0000, "stopall3");
    st = '1;
    send(16'hC040, "all_rel_drop");

    send(16'hBC40, "pre_kill");
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_data  = 16'hBC60;
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_data  = 16'h0000;
    @(negedge clk);
    chk("in_kill cmd", 80'(cmd), 80'(0));
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check_out(snap("rst_kill", 1'b0, 1'b0));
    chk("rst_kill ready", 80'(bus.o_ready), 80'(1));
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_out(snap("post_rst", 1'b0, 1'b0));
    chk("post_rst ready", 80'(bus.o_ready), 80'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
